// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between NUM_FU completion streams, with a
// one-entry output register and mispredict squash by ROB age. Optional counters: CDB_STATS_EN.
module cdb_arbiter #(
  parameter int unsigned NUM_FU       = 3,
  parameter int unsigned GPR_SIZE     = 64,
  parameter int unsigned ROB_IDX_SIZE = 4
) (
  input  logic                                 in_clk,
  input  logic                                 in_rst,
  input  logic [NUM_FU-1:0]                    in_fu_valid,
  input  logic [NUM_FU-1:0][GPR_SIZE-1:0]      in_fu_value,
  input  logic [NUM_FU-1:0][ROB_IDX_SIZE-1:0]  in_fu_rob_idx,
  input  logic [NUM_FU-1:0]                    in_fu_set_nzcv,
  input  logic [NUM_FU-1:0][3:0]               in_fu_nzcv,
  output logic [NUM_FU-1:0]                    out_fu_ready,
  input  logic                                 in_rob_ready,
  input  logic [ROB_IDX_SIZE-1:0]              in_rob_head_idx,
  input  logic                                 in_mispred,
  input  logic [ROB_IDX_SIZE-1:0]              in_mispred_rob_idx,
`ifdef CDB_STATS_EN
  output logic [NUM_FU-1:0][31:0]              out_stall_cnt,
  output logic [31:0]                          out_squash_cnt,
`endif
  output logic                                 out_cdb_valid,
  output logic [GPR_SIZE-1:0]                  out_cdb_value,
  output logic [ROB_IDX_SIZE-1:0]              out_cdb_rob_idx,
  output logic                                 out_cdb_set_nzcv,
  output logic [3:0]                           out_cdb_nzcv
);

  localparam int unsigned PtrW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    valid_q, valid_d;
  logic [GPR_SIZE-1:0]     value_q, value_d;
  logic [ROB_IDX_SIZE-1:0] rob_idx_q, rob_idx_d;
  logic                    set_nzcv_q, set_nzcv_d;
  logic [3:0]              nzcv_q, nzcv_d;

  logic            can_accept, accept, found, squash;
  logic [PtrW-1:0] winner;

  // Distance from the ROB head; larger means younger.
  function automatic logic [ROB_IDX_SIZE-1:0] age(input logic [ROB_IDX_SIZE-1:0] x,
                                                  input logic [ROB_IDX_SIZE-1:0] head);
    return x - head;
  endfunction

  function automatic logic younger(input logic [ROB_IDX_SIZE-1:0] x,
                                   input logic [ROB_IDX_SIZE-1:0] branch,
                                   input logic [ROB_IDX_SIZE-1:0] head);
    return age(x, head) > age(branch, head);
  endfunction

  assign can_accept = !valid_q || in_rob_ready;

  always_comb begin
    logic [PtrW-1:0] idx;
    out_fu_ready = '0;
    winner       = '0;
    found        = 1'b0;
    idx          = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = PtrW'((32'(rr_ptr_q) + k) % NUM_FU);
      if (!found && in_fu_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    if (can_accept && found) out_fu_ready[winner] = 1'b1;
  end

  assign accept = can_accept && found;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    valid_d    = valid_q;
    value_d    = value_q;
    rob_idx_d  = rob_idx_q;
    set_nzcv_d = set_nzcv_q;
    nzcv_d     = nzcv_q;
    squash     = 1'b0;
    if (accept) begin
      value_d    = in_fu_value[winner];
      rob_idx_d  = in_fu_rob_idx[winner];
      set_nzcv_d = in_fu_set_nzcv[winner];
      nzcv_d     = in_fu_nzcv[winner];
      valid_d    = 1'b1;
      rr_ptr_d   = (winner == PtrW'(NUM_FU - 1)) ? '0 : winner + PtrW'(1);
      // Wrong-path winner still gets its grant so the FU is released, but is dropped here.
      if (in_mispred && younger(in_fu_rob_idx[winner], in_mispred_rob_idx, in_rob_head_idx)) begin
        valid_d = 1'b0;
        squash  = 1'b1;
      end
    end else if (valid_q && in_rob_ready) begin
      valid_d = 1'b0;
    end else if (valid_q && in_mispred &&
                 younger(rob_idx_q, in_mispred_rob_idx, in_rob_head_idx)) begin
      valid_d = 1'b0;
      squash  = 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      value_q    <= '0;
      rob_idx_q  <= '0;
      set_nzcv_q <= 1'b0;
      nzcv_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      value_q    <= value_d;
      rob_idx_q  <= rob_idx_d;
      set_nzcv_q <= set_nzcv_d;
      nzcv_q     <= nzcv_d;
    end
  end

  assign out_cdb_valid    = valid_q;
  assign out_cdb_value    = value_q;
  assign out_cdb_rob_idx  = rob_idx_q;
  assign out_cdb_set_nzcv = set_nzcv_q;
  assign out_cdb_nzcv     = nzcv_q;

`ifdef CDB_STATS_EN
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_stall_cnt  <= '0;
      out_squash_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (in_fu_valid[i] && !out_fu_ready[i] && out_stall_cnt[i] != 32'hFFFF_FFFF) begin
          out_stall_cnt[i] <= out_stall_cnt[i] + 32'd1;
        end
      end
      if (squash && out_squash_cnt != 32'hFFFF_FFFF) out_squash_cnt <= out_squash_cnt + 32'd1;
    end
  end
`else
  logic unused_squash;
  assign unused_squash = squash;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_FU functional-unit completion streams. Winners go to the ROB writeback port (in_fu_done/in_fu_value/in_fu_rob_idx/in_fu_set_nzcv/in_fu_nzcv) and to the reservation-station wakeup.
- Round-robin arbitration with valid/ready handshakes per FU.
- One-entry registered output with ROB backpressure.
- Squashes wrong-path results on mispredict using ROB-relative age.

Parameters:
- NUM_FU, 3, number of requesting functional units (2..8).
- GPR_SIZE, 64, result width.
- ROB_IDX_SIZE, 4, ROB index width; ROB depth is 2**ROB_IDX_SIZE.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset, asynchronous, active-low.
- in_fu_valid  input  NUM_FU  FU i holds a completed result.
- in_fu_value  input  NUM_FU x GPR_SIZE  result value per FU.
- in_fu_rob_idx  input  NUM_FU x ROB_IDX_SIZE  destination ROB entry per FU.
- in_fu_set_nzcv  input  NUM_FU  result updates flags.
- in_fu_nzcv  input  NUM_FU x 4  flag value per FU.
- out_fu_ready  output  NUM_FU  grant; one-hot or zero.
- in_rob_ready  input  1  ROB/RS consume the CDB this cycle.
- in_rob_head_idx  input  ROB_IDX_SIZE  current ROB head (oldest entry).
- in_mispred  input  1  branch mispredict, single-cycle pulse.
- in_mispred_rob_idx  input  ROB_IDX_SIZE  ROB index of the mispredicted branch.
- out_cdb_valid  output  1  broadcast valid.
- out_cdb_value  output  GPR_SIZE  broadcast value.
- out_cdb_rob_idx  output  ROB_IDX_SIZE  broadcast ROB index.
- out_cdb_set_nzcv  output  1  broadcast flag-update enable.
- out_cdb_nzcv  output  4  broadcast flags.

Behaviour:
- Reset (in_rst=0, asynchronous): all out_cdb_* = 0; rr_ptr = 0. out_fu_ready is then 0 because it is combinational from cleared state. Reset mid-transfer drops the held entry; no partial broadcast.
- Transfer from FU i: in_fu_valid[i] && out_fu_ready[i] at a rising edge. A requester keeps its payload stable while valid && !ready. The arbiter never depends on the FU holding valid low.
- can_accept = !out_cdb_valid || in_rob_ready (combinational).
- Grant:
  - When can_accept, out_fu_ready is one-hot on the first i with in_fu_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - When !can_accept, all ready bits are 0.
  - No valid requests gives all zeros.
- rr_ptr updates to (winner+1) mod NUM_FU on a transfer; otherwise it holds. Wrap: winner NUM_FU-1 gives rr_ptr 0.
- Latency: FU accepted at edge N appears on out_cdb_* from edge N until it is consumed. Consumption is out_cdb_valid && in_rob_ready at an edge.
- Consume and accept at the same edge: the new entry replaces the old with no bubble, so throughput is 1/cycle.
- Consume with no accept: out_cdb_valid goes to 0. Payload fields may hold stale values.
- Held entry (out_cdb_valid && !in_rob_ready): all out_cdb_* stay stable.
- Age: age(x) = (x - in_rob_head_idx) mod 2**ROB_IDX_SIZE, unsigned ROB_IDX_SIZE-bit subtract. x is younger than the branch iff age(x) > age(in_mispred_rob_idx). Equal age (the branch itself) is kept.
- Mispredict cycle (in_mispred=1):
  - A held output entry younger than the branch is cleared, so out_cdb_valid=0 after the edge.
  - An entry accepted this edge that is younger is accepted (ready still asserted, FU released) but discarded, so out_cdb_valid=0.
  - Older entries proceed normally.
  - Arbitration and rr_ptr update are unaffected.
- Mispredict and reset together: reset wins.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined:
  - Adds output out_stall_cnt, NUM_FU x 32. Per FU, it is a saturating counter of cycles with in_fu_valid[i]=1 && out_fu_ready[i]=0.
  - Cleared by reset; holds at 32'hFFFFFFFF.
  - Adds output out_squash_cnt, 32-bit saturating count of entries discarded by mispredict.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single request: FU1 valid, value 64'h1234, rob_idx 5, in_rob_ready=1 → out_fu_ready=3'b010 that cycle; next cycle out_cdb_valid=1, value 64'h1234, rob_idx 5; rr_ptr=2.
- Round robin: all three FUs valid continuously, in_rob_ready=1, after reset → grant order FU0, FU1, FU2, FU0; one broadcast per cycle, no bubbles.
- Backpressure: entry held with in_rob_ready=0 for 3 cycles while FU2 valid → out_cdb_* stable, out_fu_ready=0. in_rob_ready=1 → FU2 granted that cycle and broadcast on the next.
- Mispredict wrap: head=14, branch idx=1, held entry idx=3 (age 5 > age 3) → cleared. Repeat with held idx=15 (age 1) → retained and broadcast.
- Simultaneous: in_mispred with branch idx 4, head 0, FU0 accepting idx 6 → out_fu_ready[0]=1, out_cdb_valid=0 next cycle. With CDB_STATS_EN, out_squash_cnt increments by 1.
- Async reset asserted mid-hold → out_cdb_valid=0 immediately without a clock edge. After release, FU2 alone is granted and rr_ptr becomes 0.
